// File: rtl/traffic_light_lamp_driver.sv
// traffic_light_lamp_driver: decodes the 4-bit light_signal bus into per-lane lamps and latches flashing all-red on any sequence violation
// ports: clk, rst (sync, active-high), light_signal[3:0], fault_clr -> lamp_red/yellow/green[3:0] (0=NS1 1=NS2 2=EW1 3=EW2), fault, fault_code[2:0]
module traffic_light_lamp_driver #(
  parameter int MIN_ALLRED = 1,
  parameter int MAX_GREEN  = 2,
  parameter int MAX_YELLOW = 1,
  parameter int FLASH_HALF = 4,
  parameter int CNT_W      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] light_signal,
  input  logic       fault_clr,
  output logic [3:0] lamp_red,
  output logic [3:0] lamp_yellow,
  output logic [3:0] lamp_green,
  output logic       fault,
  output logic [2:0] fault_code
);
  localparam logic [CNT_W-1:0] SAT = '1;
  logic [3:0] prev_code, lane_oh;
  logic [1:0] cur_lane, prev_lane;
  logic [CNT_W-1:0] run_cnt, red_cnt, flash_cnt, run_nxt, red_nxt;
  logic illegal, cur_red, cur_grn, cur_yel, prv_red, prv_grn, bad_trans;
  logic [2:0] cause;
  always_comb begin
    illegal   = light_signal > 4'd8;
    cur_red   = light_signal == 4'd0;
    cur_grn   = !illegal && light_signal[0];
    cur_yel   = !illegal && !cur_red && !light_signal[0];
    prv_red   = prev_code == 4'd0;
    prv_grn   = prev_code[0];
    // lanes pair up as (1,2) (3,4) (5,6) (7,8); 3-bit wrap maps code 8 onto lane 3
    cur_lane  = 2'((light_signal[2:0] - 3'd1) >> 1);
    prev_lane = 2'((prev_code[2:0] - 3'd1) >> 1);
    lane_oh   = 4'b0001 << cur_lane;
    bad_trans = prv_red ? cur_yel :
                prv_grn ? !((cur_grn || cur_yel) && cur_lane == prev_lane) :
                          !(cur_red || (cur_yel && cur_lane == prev_lane));
    run_nxt   = light_signal != prev_code ? CNT_W'(1) : run_cnt == SAT ? SAT : run_cnt + 1'b1;
    red_nxt   = !cur_red ? red_cnt : !prv_red ? CNT_W'(1) : red_cnt == SAT ? SAT : red_cnt + 1'b1;
    cause     = illegal                                        ? 3'd1 :
                bad_trans                                      ? 3'd2 :
                cur_grn && run_nxt > CNT_W'(MAX_GREEN)         ? 3'd3 :
                cur_yel && run_nxt > CNT_W'(MAX_YELLOW)        ? 3'd4 :
                prv_red && cur_grn && red_cnt < CNT_W'(MIN_ALLRED) ? 3'd5 : 3'd0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      lamp_red    <= 4'hF;
      lamp_yellow <= 4'h0;
      lamp_green  <= 4'h0;
      fault       <= 1'b0;
      fault_code  <= 3'd0;
      prev_code   <= 4'd0;
      run_cnt     <= '0;
      red_cnt     <= CNT_W'(MIN_ALLRED);
      flash_cnt   <= '0;
    end else if (fault) begin
      if (fault_clr && cur_red) begin
        fault      <= 1'b0;
        fault_code <= 3'd0;
        lamp_red   <= 4'hF;
        prev_code  <= 4'd0;
        run_cnt    <= CNT_W'(1);
        red_cnt    <= CNT_W'(1);
      end else if (flash_cnt == CNT_W'(FLASH_HALF - 1)) begin
        flash_cnt <= '0;
        lamp_red  <= ~lamp_red;
      end else begin
        flash_cnt <= flash_cnt + 1'b1;
      end
    end else if (cause != 3'd0) begin
      fault       <= 1'b1;
      fault_code  <= cause;
      lamp_red    <= 4'hF;
      lamp_yellow <= 4'h0;
      lamp_green  <= 4'h0;
      flash_cnt   <= '0;
    end else begin
      prev_code   <= light_signal;
      run_cnt     <= run_nxt;
      red_cnt     <= red_nxt;
      lamp_red    <= cur_red ? 4'hF : ~lane_oh;
      lamp_yellow <= cur_yel ? lane_oh : 4'h0;
      lamp_green  <= cur_grn ? lane_oh : 4'h0;
    end
  end
endmodule

// File: tb/tb_traffic_light_lamp_driver.sv
// tb_traffic_light_lamp_driver: scoreboard bench; stimulus byte = {rst, fault_clr, 2'b0, code}, expected word = {red, yellow, green, fault, fault_code}
module tb_traffic_light_lamp_driver;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [3:0] light_signal = 4'd0;
  logic fault_clr = 1'b0;
  logic [3:0] a_red, a_yel, a_grn, b_red, b_yel, b_grn;
  logic a_fault, b_fault;
  logic [2:0] a_code, b_code;
  logic [15:0] out_a, out_b, exp;
  logic [15:0] sb[$];
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  assign out_a = {a_red, a_yel, a_grn, a_fault, a_code};
  assign out_b = {b_red, b_yel, b_grn, b_fault, b_code};
  traffic_light_lamp_driver dut_a (
    .clk(clk), .rst(rst), .light_signal(light_signal), .fault_clr(fault_clr),
    .lamp_red(a_red), .lamp_yellow(a_yel), .lamp_green(a_grn), .fault(a_fault), .fault_code(a_code)
  );
  traffic_light_lamp_driver #(.MIN_ALLRED(2)) dut_b (
    .clk(clk), .rst(rst), .light_signal(light_signal), .fault_clr(fault_clr),
    .lamp_red(b_red), .lamp_yellow(b_yel), .lamp_green(b_grn), .fault(b_fault), .fault_code(b_code)
  );
  task automatic apply(input logic [7:0] s, input logic [15:0] e);
    rst = s[7];
    fault_clr = s[6];
    light_signal = s[3:0];
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    logic [7:0] st[7] = '{8'h80, 8'h81, 8'h01, 8'h80, 8'h0A, 8'h00, 8'h80};
    logic [15:0] ex[7] = '{16'hF000, 16'hF000, 16'hE010, 16'hF000, 16'hF009, 16'hF009, 16'hF000};
    for (int i = 0; i < 7; i++) begin
      apply(st[i], ex[i]);
      exp = sb.pop_front();
      total++;
      if (out_a !== exp) begin bad++; $display("FAIL reset step %0d: got %h want %h", i, out_a, exp); end
    end
  endtask
  task automatic test_normal();
    logic [7:0] st[13] = '{8'h80, 8'h00, 8'h01, 8'h01, 8'h02, 8'h00, 8'h07, 8'h08, 8'h00, 8'h03, 8'h04, 8'h00, 8'h05};
    logic [15:0] ex[13] = '{16'hF000, 16'hF000, 16'hE010, 16'hE010, 16'hE100, 16'hF000, 16'h7080,
                            16'h7800, 16'hF000, 16'hD020, 16'hD200, 16'hF000, 16'hB040};
    for (int i = 0; i < 13; i++) begin
      apply(st[i], ex[i]);
      exp = sb.pop_front();
      total++;
      if (out_a !== exp) begin bad++; $display("FAIL normal step %0d: got %h want %h", i, out_a, exp); end
    end
  endtask
  task automatic test_green_overrun();
    logic [7:0] st[13] = '{8'h80, 8'h00, 8'h01, 8'h01, 8'h01, 8'h0F, 8'h00, 8'h03,
                           8'h09, 8'h00, 8'h02, 8'h00, 8'h01};
    logic [15:0] ex[13] = '{16'hF000, 16'hF000, 16'hE010, 16'hE010, 16'hF00B, 16'hF00B, 16'hF00B,
                            16'hF00B, 16'h000B, 16'h000B, 16'h000B, 16'h000B, 16'hF00B};
    for (int i = 0; i < 13; i++) begin
      apply(st[i], ex[i]);
      exp = sb.pop_front();
      total++;
      if (out_a !== exp) begin bad++; $display("FAIL green_overrun step %0d: got %h want %h", i, out_a, exp); end
    end
  endtask
  task automatic test_illegal();
    logic [7:0] st[6] = '{8'h80, 8'h00, 8'h0A, 8'h80, 8'h01, 8'h09};
    logic [15:0] ex[6] = '{16'hF000, 16'hF000, 16'hF009, 16'hF000, 16'hE010, 16'hF009};
    for (int i = 0; i < 6; i++) begin
      apply(st[i], ex[i]);
      exp = sb.pop_front();
      total++;
      if (out_a !== exp) begin bad++; $display("FAIL illegal step %0d: got %h want %h", i, out_a, exp); end
    end
  endtask
  task automatic test_bad_transition();
    logic [7:0] st[18] = '{8'h80, 8'h00, 8'h01, 8'h03, 8'h80, 8'h01, 8'h00, 8'h80, 8'h00, 8'h02,
                           8'h80, 8'h01, 8'h02, 8'h04, 8'h80, 8'h01, 8'h02, 8'h01};
    logic [15:0] ex[18] = '{16'hF000, 16'hF000, 16'hE010, 16'hF00A, 16'hF000, 16'hE010, 16'hF00A,
                            16'hF000, 16'hF000, 16'hF00A, 16'hF000, 16'hE010, 16'hE100, 16'hF00A,
                            16'hF000, 16'hE010, 16'hE100, 16'hF00A};
    for (int i = 0; i < 18; i++) begin
      apply(st[i], ex[i]);
      exp = sb.pop_front();
      total++;
      if (out_a !== exp) begin bad++; $display("FAIL bad_transition step %0d: got %h want %h", i, out_a, exp); end
    end
  endtask
  task automatic test_yellow_overrun();
    logic [7:0] st[4] = '{8'h80, 8'h07, 8'h08, 8'h08};
    logic [15:0] ex[4] = '{16'hF000, 16'h7080, 16'h7800, 16'hF00C};
    for (int i = 0; i < 4; i++) begin
      apply(st[i], ex[i]);
      exp = sb.pop_front();
      total++;
      if (out_a !== exp) begin bad++; $display("FAIL yellow_overrun step %0d: got %h want %h", i, out_a, exp); end
    end
  endtask
  task automatic test_clearance();
    logic [7:0] st[11] = '{8'h80, 8'h01, 8'h02, 8'h00, 8'h03, 8'h80, 8'h01, 8'h02, 8'h00, 8'h00, 8'h03};
    logic [15:0] ex[11] = '{16'hF000, 16'hE010, 16'hE100, 16'hF000, 16'hF00D, 16'hF000, 16'hE010,
                            16'hE100, 16'hF000, 16'hF000, 16'hD020};
    for (int i = 0; i < 11; i++) begin
      apply(st[i], ex[i]);
      exp = sb.pop_front();
      total++;
      if (out_b !== exp) begin bad++; $display("FAIL clearance step %0d: got %h want %h", i, out_b, exp); end
    end
  endtask
  task automatic test_fault_clear();
    logic [7:0] st[9] = '{8'h80, 8'h00, 8'h0A, 8'h41, 8'h00, 8'h40, 8'h03, 8'h44, 8'h00};
    logic [15:0] ex[9] = '{16'hF000, 16'hF000, 16'hF009, 16'hF009, 16'hF009, 16'hF000, 16'hD020,
                           16'hD200, 16'hF000};
    for (int i = 0; i < 9; i++) begin
      apply(st[i], ex[i]);
      exp = sb.pop_front();
      total++;
      if (out_a !== exp) begin bad++; $display("FAIL fault_clear step %0d: got %h want %h", i, out_a, exp); end
    end
  endtask
  initial begin
    test_reset();
    test_normal();
    test_green_overrun();
    test_illegal();
    test_bad_transition();
    test_yellow_overrun();
    test_clearance();
    test_fault_clear();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/traffic_light_lamp_driver.md
Name: traffic_light_lamp_driver

Overview:
- Receiving end of the encoded 4-bit `light_signal` bus driven by the intersection controller FSM.
- Each cycle it decodes the code into per-lane red/yellow/green lamp drives, so the lamp hardware never sees the encoded value.
- In parallel it runs a conflict/sequence monitor on the code stream: illegal code, skipped yellow, over-long green/yellow, insufficient all-red clearance.
- On any violation it latches a fault and drives flashing all-red until cleared.

Parameters:
- MIN_ALLRED, 1: minimum consecutive all-red (code 0000) cycles required before any green.
- MAX_GREEN, 2: maximum consecutive cycles one green code may persist.
- MAX_YELLOW, 1: maximum consecutive cycles one yellow code may persist.
- FLASH_HALF, 4: half-period, in cycles, of the fault-mode red flash.
- CNT_W, 8: width of the internal run/flash counters; all counters saturate at 2^CNT_W-1.

Ports:
- clk, in, 1: system clock; everything is on the rising edge.
- rst, in, 1: synchronous, active-high reset.
- light_signal, in, 4: encoded controller output.
- fault_clr, in, 1: single-cycle request to leave fault mode.
- lamp_red, out, 4: red lamp per lane. Bit index: 0=NS1, 1=NS2, 2=EW1, 3=EW2.
- lamp_yellow, out, 4: yellow lamp per lane, same indexing.
- lamp_green, out, 4: green lamp per lane, same indexing.
- fault, out, 1: latched fault flag.
- fault_code, out, 3: cause of the latched fault; 0 when no fault.

Behaviour:
- Code map:
  - 0000: all red.
  - 0001 / 0010: NS1 green / yellow.
  - 0011 / 0100: NS2 green / yellow.
  - 0101 / 0110: EW1 green / yellow.
  - 0111 / 1000: EW2 green / yellow.
  - 1001–1111: illegal.
- Lamp decode rule: the active lane shows G or Y; every other lane shows R. Exactly one lamp per lane is lit in normal mode.
- Latency: lamps and fault outputs are registered. `light_signal` sampled at edge N is reflected on the outputs immediately after edge N.
- Internal state:
  - `prev_code`: last sampled code.
  - `run_cnt`: consecutive cycles of the current code, including the current one.
  - `red_cnt`: length of the current/most recent all-red run.
- Legal transitions (prev -> cur):
  - 0000 -> 0000.
  - 0000 -> any green, only if `red_cnt` >= MIN_ALLRED.
  - green L -> green L (requires `run_cnt` <= MAX_GREEN).
  - green L -> yellow L.
  - yellow L -> yellow L (requires `run_cnt` <= MAX_YELLOW).
  - yellow L -> 0000.
- Fault causes, checked each edge while not in fault:
  - 1: illegal code.
  - 2: illegal transition (green→other green, green→0000, green→other yellow, yellow→any green, yellow→other yellow, 0000→yellow).
  - 3: green run exceeds MAX_GREEN.
  - 4: yellow run exceeds MAX_YELLOW.
  - 5: green after an all-red run shorter than MIN_ALLRED.
- Multiple simultaneous causes: the lowest code number wins.
- Fault entry, at the detecting edge:
  - fault=1 and fault_code set.
  - The offending code is never decoded to lamps.
  - lamp_yellow=0, lamp_green=0, lamp_red=1111.
  - Flash phase=1, flash counter=0.
- While in fault:
  - Inputs are ignored except `fault_clr`.
  - lamp_red toggles between 1111 and 0000 every FLASH_HALF cycles.
  - fault_code is held.
- Fault clear: on an edge with fault_clr=1 AND light_signal=0000:
  - fault=0, fault_code=0, lamp_red=1111.
  - prev_code=0000, red_cnt=1.
  - Normal checking resumes from the next edge.
- fault_clr with a non-zero code is ignored. fault_clr while not in fault has no effect.
- Reset (any time, including mid-fault or mid-green):
  - lamp_red=1111, lamp_yellow=0000, lamp_green=0000.
  - fault=0, fault_code=0.
  - prev_code=0000, run_cnt=0.
  - red_cnt=MIN_ALLRED, so a green on the first edge after reset release is legal.
- Counters saturate and never wrap. A saturated `red_cnt` still satisfies clearance.

Test Plan:
- Normal NS1 sequence 0000,0001,0001,0010,0000 (defaults):
  - lamps green=0001 for 2 cycles, then yellow=0001, then red=1111.
  - Other lanes red throughout; fault stays 0.
- 0000,0001,0001,0001 (MAX_GREEN=2):
  - fault=1, fault_code=3 at the 3rd green edge; lamp_green=0, lamp_red=1111.
  - Red toggles to 0000 after 4 cycles and back to 1111 after 4 more.
- Code 1010 after 0000: fault_code=1; no lamp decode of 1010 visible.
- 0000,0001,0011: fault_code=2 on the 0011 edge. Separately, 0001,0000 (skipped yellow): fault_code=2.
- MIN_ALLRED=2, sequence 0010,0000,0011: fault_code=5.
- Fault clear and reset:
  - While faulted, fault_clr=1 with code 0001: remains faulted.
  - fault_clr=1 with 0000: fault=0, lamp_red=1111; a following 0011 is legal.
  - Reset asserted mid-fault: all outputs at reset values on the next edge.
